cbus_ram_responder: RTL and testbench
=====================================

// Module: cbus_ram_responder
// PURPOSE
//  Responder (memory side) of the simplified burst cache bus (cbus_req_t/cbus_resp_t, package common).
//  Serves burst reads/writes from an internal 64-bit-word RAM with programmable first-beat latency.
//  Sits below the I/D caches in simulation tops; also the reference slave for cache verification.
// PARAMETERS
//  MEM_WORDS  4096            RAM depth in 64-bit words
//  BASE_ADDR  64'h8000_0000   byte address of word 0 (PCINIT region)
//  LATENCY    2               idle cycles between request acceptance and first beat (0..15)
// PORTS
//  clk      in   1    clock
//  reset    in   1    synchronous, active-high reset
//  req      in   151  cbus_req_t {valid,is_write,size,addr,strobe,data,len,burst}
//  resp     out  66   cbus_resp_t {ready,last,data}
//  oob      out  1    sticky: some beat addressed outside RAM; cleared only by reset
// BEHAVIOUR
//  - Reset: state=IDLE, resp.ready=0, resp.last=0, resp.data=0, oob=0. RAM contents NOT cleared.
//  - FSM: IDLE -> WAIT -> BEAT -> GAP -> IDLE. All resp fields are registered.
//  - IDLE: req.valid=1 at an edge captures is_write, size, addr, len, burst; beat counter=0, latency counter=0.
//    LATENCY=0 skips WAIT and goes to BEAT.
//  - WAIT: runs exactly LATENCY cycles, then BEAT. First resp.ready is seen LATENCY+1 cycles after acceptance.
//  - BEAT: resp.ready=1 every cycle, one beat per cycle, no bubbles. resp.last=1 on beat index == len.
//    * read: resp.data = RAM word holding the current beat address, registered on the edge entering the beat.
//    * write: on each edge with resp.ready=1, write req.data byte i into the word iff req.strobe[i].
//      req.data/strobe are sampled per beat; resp.data=0 on writes.
//  - After the last beat: GAP for 1 cycle (ready=0). The master drops valid here; req is ignored in GAP.
//    Next acceptance is from IDLE at the earliest.
//  - Beat address: word index = (addr-BASE_ADDR)>>3. Byte lanes are word-aligned, per the dbus strobe convention.
//    * INCR: addr += 1<<size per beat.
//    * FIXED: addr unchanged.
//    * WRAP: addr = base | ((addr + (1<<size)) & mask).
//      mask = (len+1)*(1<<size)-1; base = start addr & ~mask.
//    * RESERVED: treated as INCR.
//    * Address arithmetic is 64-bit, modulo 2^64.
//  - Out-of-range beat (addr < BASE or index >= MEM_WORDS):
//    * read returns 0; write is dropped.
//    * oob is set; the burst still completes with normal ready/last timing.
//  - req.valid falls in WAIT or BEAT (abort): go to IDLE next cycle, ready/last=0.
//    No write is performed on the beat edge at which valid=0.
//  - Reset asserted at any state wins: IDLE next cycle, outputs to reset values.
//    A partially written burst stays partially written.
//  - len=MLEN1: a single beat with ready=1 and last=1 together.
// TESTING
//  1. LATENCY=2, read INCR len=MLEN4 size=MSIZE8 @0x8000_0000, RAM[i]=i+0x100
//     -> ready on cycles 3..6, data 0x100..0x103, last only on cycle 6.
//  2. Write INCR len=MLEN2 @0x8000_0010, data A then B, strobe 8'hFF then 8'h0F
//     -> RAM[2]=A; RAM[3] low 4 bytes=B[31:0], high bytes unchanged.
//  3. WRAP len=MLEN4 size=MSIZE8 start 0x8000_0028
//     -> beat words 5,6,7,4; last on word 4.
//  4. Read @0x7FFF_FFF8 len=MLEN2 -> beats data 0 then RAM[0]; oob=1 and stays 1 until reset.
//  5. Write burst len=MLEN8; drop valid after beat 3 -> words 0..2 written, 3..7 untouched; FSM in IDLE next cycle.
//  6. Reset pulsed during WAIT -> ready=0 next cycle; a new request afterwards completes with normal timing.

Source files
------------

// File: rtl/cbus_ram_responder.sv
// Memory-side responder of the burst cache bus: serves INCR/FIXED/WRAP bursts
// from an internal 64-bit-word RAM after a programmable first-beat latency.
module cbus_ram_responder #(
    parameter int unsigned MEM_WORDS = 4096,
    parameter logic [63:0] BASE_ADDR = 64'h8000_0000,
    parameter int unsigned LATENCY   = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [150:0] req,
    output logic [65:0]  resp,
    output logic         oob
);
    localparam int unsigned AW       = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [3:0]  LAT_LAST = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);
    localparam logic [1:0]  BURST_FIXED = 2'd0;
    localparam logic [1:0]  BURST_WRAP  = 2'd2;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BEAT, S_GAP} state_t;

    logic        req_valid;
    logic        req_is_write;
    logic [2:0]  req_size;
    logic [63:0] req_addr;
    logic [7:0]  req_strobe;
    logic [63:0] req_data;
    logic [7:0]  req_len;
    logic [1:0]  req_burst;

    assign {req_valid, req_is_write, req_size, req_addr,
            req_strobe, req_data, req_len, req_burst} = req;

    state_t      state;
    state_t      state_next;

    logic        is_write_q;
    logic [2:0]  size_q;
    logic [7:0]  len_q;
    logic [1:0]  burst_q;
    logic [63:0] addr_q;
    logic [63:0] wrap_base_q;
    logic [63:0] wrap_mask_q;
    logic [7:0]  beat_q;
    logic [3:0]  lat_q;
    logic        ready_q;
    logic        last_q;
    logic [63:0] data_q;
    logic        oob_q;

    logic [63:0] mem [MEM_WORDS];

    logic [63:0] step;
    logic [63:0] addr_adv;
    logic [63:0] cap_mask;

    logic        present;
    logic [63:0] pres_addr;
    logic [7:0]  pres_beat;
    logic        pres_write;
    logic [7:0]  pres_len;
    logic [63:0] pres_word;
    logic        pres_ok;
    logic        ready_next;
    logic        last_next;
    logic [63:0] data_next;
    logic        oob_set;
    logic [63:0] wr_word;
    logic        mem_we;

    assign cap_mask = ((64'(req_len) + 64'd1) << req_size) - 64'd1;

    always_comb begin
        step = 64'd1 << size_q;
        case (burst_q)
            BURST_FIXED: addr_adv = addr_q;
            BURST_WRAP:  addr_adv = wrap_base_q | ((addr_q + step) & wrap_mask_q);
            default:     addr_adv = addr_q + step;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (req_valid) begin
                    state_next = (LATENCY == 0) ? S_BEAT : S_WAIT;
                end
            end
            S_WAIT: begin
                if (!req_valid) begin
                    state_next = S_IDLE;
                end else if (lat_q == LAT_LAST) begin
                    state_next = S_BEAT;
                end
            end
            S_BEAT: begin
                if (!req_valid) begin
                    state_next = S_IDLE;
                end else if (beat_q == len_q) begin
                    state_next = S_GAP;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Outputs are registered, so this computes the beat that becomes visible
    // after the coming edge ("present") and its address/data.
    always_comb begin
        present    = 1'b0;
        pres_addr  = addr_q;
        pres_beat  = beat_q;
        pres_write = is_write_q;
        pres_len   = len_q;
        case (state)
            S_IDLE: begin
                if (req_valid && (LATENCY == 0)) begin
                    present    = 1'b1;
                    pres_addr  = req_addr;
                    pres_beat  = '0;
                    pres_write = req_is_write;
                    pres_len   = req_len;
                end
            end
            S_WAIT: begin
                if (req_valid && (lat_q == LAT_LAST)) begin
                    present   = 1'b1;
                    pres_beat = '0;
                end
            end
            S_BEAT: begin
                if (req_valid && (beat_q != len_q)) begin
                    present   = 1'b1;
                    pres_addr = addr_adv;
                    pres_beat = beat_q + 8'd1;
                end
            end
            default: ;
        endcase

        pres_word  = (pres_addr - BASE_ADDR) >> 3;
        pres_ok    = (pres_addr >= BASE_ADDR) && (pres_word < 64'(MEM_WORDS));
        ready_next = present;
        last_next  = present && (pres_beat == pres_len);
        data_next  = (present && !pres_write && pres_ok) ? mem[pres_word[AW-1:0]] : '0;
        oob_set    = present && !pres_ok;

        wr_word = (addr_q - BASE_ADDR) >> 3;
        mem_we  = (state == S_BEAT) && req_valid && is_write_q && !reset &&
                  (addr_q >= BASE_ADDR) && (wr_word < 64'(MEM_WORDS));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ready_q <= 1'b0;
            last_q  <= 1'b0;
            data_q  <= '0;
            oob_q   <= 1'b0;
            beat_q  <= '0;
            lat_q   <= '0;
        end else begin
            ready_q <= ready_next;
            last_q  <= last_next;
            data_q  <= data_next;
            if (oob_set) begin
                oob_q <= 1'b1;
            end
            if (state == S_IDLE && req_valid) begin
                is_write_q  <= req_is_write;
                size_q      <= req_size;
                len_q       <= req_len;
                burst_q     <= req_burst;
                wrap_mask_q <= cap_mask;
                wrap_base_q <= req_addr & ~cap_mask;
                lat_q       <= '0;
            end else if (state == S_WAIT) begin
                lat_q <= lat_q + 4'd1;
            end
            if (present) begin
                addr_q <= pres_addr;
                beat_q <= pres_beat;
            end else if (state == S_IDLE && req_valid) begin
                addr_q <= req_addr;
                beat_q <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int unsigned i = 0; i < 8; i++) begin
                if (req_strobe[i]) begin
                    mem[wr_word[AW-1:0]][8*i +: 8] <= req_data[8*i +: 8];
                end
            end
        end
    end

    assign resp = {ready_q, last_q, data_q};
    assign oob  = oob_q;

endmodule

// File: tb/tb_cbus_ram_responder.sv
// Randomized bench for cbus_ram_responder: a transaction-level model predicts the
// response of every cycle; a few fixed scenarios pin the model with literal values.
module tb_cbus_ram_responder;
    localparam int unsigned MW    = 64;
    localparam int          LAT   = 2;
    localparam logic [63:0] BASE  = 64'h8000_0000;
    localparam int          NEVER = 32'h7fff_ffff;

    logic         clk   = 1'b0;
    logic         reset = 1'b1;
    logic [150:0] req;
    logic [65:0]  resp;
    logic         oob;

    logic        r_valid  = 1'b0;
    logic        r_write  = 1'b0;
    logic [2:0]  r_size   = '0;
    logic [63:0] r_addr   = '0;
    logic [7:0]  r_strobe = '0;
    logic [63:0] r_data   = '0;
    logic [7:0]  r_len    = '0;
    logic [1:0]  r_burst  = '0;

    assign req = {r_valid, r_write, r_size, r_addr, r_strobe, r_data, r_len, r_burst};

    cbus_ram_responder #(
        .MEM_WORDS(MW),
        .BASE_ADDR(BASE),
        .LATENCY(LAT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .req(req),
        .resp(resp),
        .oob(oob)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          errors = 0;
    int          checks = 0;
    bit          chk_en = 1'b0;
    logic [63:0] mmem [MW];
    logic [65:0] exp_rsp [int];
    logic [65:0] act [int];
    int          oob_edge = NEVER;
    logic [63:0] wdata_q [$];
    logic [7:0]  wstrb_q [$];
    logic [65:0] exp_now;
    logic        exp_oob;

    // Per-cycle compare: anything without an expected beat must be all zeros.
    always @(negedge clk) begin
        if (chk_en) begin
            exp_now  = exp_rsp.exists(cyc) ? exp_rsp[cyc] : '0;
            exp_oob  = (cyc >= oob_edge);
            act[cyc] = resp;
            checks++;
            if (resp !== exp_now) begin
                errors++;
                $display("FAIL resp @%0d: got ready=%b last=%b data=%h, want ready=%b last=%b data=%h",
                         cyc, resp[65], resp[64], resp[63:0], exp_now[65], exp_now[64], exp_now[63:0]);
            end
            checks++;
            if (oob !== exp_oob) begin
                errors++;
                $display("FAIL oob @%0d: got %b want %b", cyc, oob, exp_oob);
            end
        end
    end

    function automatic bit in_rng(input logic [63:0] a);
        return (a >= BASE) && (((a - BASE) >> 3) < 64'(MW));
    endfunction

    function automatic int widx(input logic [63:0] a);
        return int'((a - BASE) >> 3);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [65:0] got, input logic [65:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic do_reset(input int n);
        r_valid = 1'b0;
        reset   = 1'b1;
        repeat (n) begin
            tick();
            exp_rsp.delete();
            oob_edge = NEVER;
        end
        reset = 1'b0;
    endtask

    // Drives one request from the next edge (k) on. abort_off>0 drops valid at edge k+abort_off.
    task automatic burst(input bit wr, input logic [2:0] sz, input logic [63:0] a0,
                         input logic [7:0] len, input logic [1:0] bt, input int abort_off,
                         input bit hold_gap, output int k);
        logic [63:0] addrs [$];
        logic [63:0] a, step, mask, wbase, d;
        logic [7:0]  s;
        int          last_edge, b, idx, n;
        n     = int'(len);
        step  = 64'd1 << sz;
        mask  = ((64'(len) + 64'd1) << sz) - 64'd1;
        wbase = a0 & ~mask;
        a     = a0;
        for (int i = 0; i <= n; i++) begin
            addrs.push_back(a);
            if (bt == 2'd2) a = wbase | ((a + step) & mask);
            else if (bt != 2'd0) a = a + step;
        end
        k = cyc + 1;
        for (int i = 0; i <= n; i++) begin
            if (abort_off == 0 || LAT + i < abort_off) begin
                d = (!wr && in_rng(addrs[i])) ? mmem[widx(addrs[i])] : '0;
                exp_rsp[k + LAT + i] = {1'b1, (i == n), d};
                if (!in_rng(addrs[i]) && (k + LAT + i) < oob_edge) oob_edge = k + LAT + i;
            end
        end
        last_edge = (abort_off != 0) ? k + abort_off : k + LAT + 2 + n;
        r_write = wr;
        r_size  = sz;
        r_addr  = a0;
        r_len   = len;
        r_burst = bt;
        for (int e = k; e <= last_edge; e++) begin
            b = e - k - LAT - 1;
            if (abort_off != 0) r_valid = (e - k < abort_off);
            else r_valid = (e - k <= LAT + 1 + n) || hold_gap;
            if (b >= 0 && b <= n && wdata_q.size() > 0) begin
                d = wdata_q.pop_front();
                s = wstrb_q.pop_front();
            end else begin
                d = {$urandom, $urandom};
                s = 8'($urandom);
            end
            r_data   = d;
            r_strobe = s;
            if (wr && r_valid && b >= 0 && b <= n && in_rng(addrs[b])) begin
                idx = widx(addrs[b]);
                for (int j = 0; j < 8; j++) if (s[j]) mmem[idx][8*j +: 8] = d[8*j +: 8];
            end
            tick();
        end
        r_valid = 1'b0;
        wdata_q.delete();
        wstrb_q.delete();
    endtask

    initial begin
        int k;
        tick();
        chk_en = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        chk("reset_resp", resp, '0);
        chk("reset_oob", {65'd0, oob}, 66'd0);

        for (int i = 0; i < int'(MW); i++) begin
            wdata_q.push_back(64'h100 + 64'(i));
            wstrb_q.push_back(8'hFF);
        end
        burst(1'b1, 3'd3, BASE, 8'(MW - 1), 2'd1, 0, 1'b0, k);
        chk("model_word5", {2'b00, mmem[5]}, {2'b00, 64'h105});

        // Four-beat INCR read: ready on cycles 3..6 after acceptance
        burst(1'b0, 3'd3, BASE, 8'd3, 2'd1, 0, 1'b0, k);
        chk("t1_before", act[k + 1], '0);
        for (int i = 0; i < 4; i++) chk("t1_beat", act[k + 2 + i], {1'b1, (i == 3), 64'h100 + 64'(i)});
        chk("t1_after", act[k + 6], '0);

        // Strobed write, then read back
        wdata_q.push_back(64'hDEAD_BEEF_0123_4567); wstrb_q.push_back(8'hFF);
        wdata_q.push_back(64'h0BAD_F00D_CAFE_1234); wstrb_q.push_back(8'h0F);
        burst(1'b1, 3'd3, BASE + 64'h10, 8'd1, 2'd1, 0, 1'b0, k);
        chk("t2_wr_data0", act[k + 2], {1'b1, 1'b0, 64'd0});
        burst(1'b0, 3'd3, BASE + 64'h10, 8'd1, 2'd1, 0, 1'b1, k);
        chk("t2_word2", act[k + 2], {1'b1, 1'b0, 64'hDEAD_BEEF_0123_4567});
        chk("t2_word3", act[k + 3], {1'b1, 1'b1, 64'h0000_0000_CAFE_1234});

        // WRAP: words 5,6,7,4
        burst(1'b0, 3'd3, BASE + 64'h28, 8'd3, 2'd2, 0, 1'b0, k);
        chk("t3_b0", act[k + 2], {1'b1, 1'b0, 64'h105});
        chk("t3_b1", act[k + 3], {1'b1, 1'b0, 64'h106});
        chk("t3_b2", act[k + 4], {1'b1, 1'b0, 64'h107});
        chk("t3_b3", act[k + 5], {1'b1, 1'b1, 64'h104});

        // Straddling the bottom of RAM
        burst(1'b0, 3'd3, 64'h7FFF_FFF8, 8'd1, 2'd1, 0, 1'b0, k);
        chk("t4_b0", act[k + 2], {1'b1, 1'b0, 64'd0});
        chk("t4_b1", act[k + 3], {1'b1, 1'b1, 64'h100});
        chk("t4_oob", {65'd0, oob}, 66'd1);

        // Write aborted at the exit edge of beat 3, then an immediate read
        for (int i = 0; i < 8; i++) begin
            wdata_q.push_back(64'h5A00 + 64'(i));
            wstrb_q.push_back(8'hFF);
        end
        burst(1'b1, 3'd3, BASE + 64'h140, 8'd7, 2'd1, LAT + 4, 1'b0, k);
        burst(1'b0, 3'd3, BASE + 64'h140, 8'd7, 2'd1, 0, 1'b0, k);
        for (int i = 0; i < 8; i++)
            chk("t5_word", act[k + 2 + i],
                {1'b1, (i == 7), (i < 3) ? 64'h5A00 + 64'(i) : 64'h100 + 64'(40 + i)});
        chk("t5_oob_sticky", {65'd0, oob}, 66'd1);

        // Reset during WAIT
        r_valid = 1'b1; r_write = 1'b0; r_size = 3'd3; r_addr = BASE; r_len = 8'd3; r_burst = 2'd1;
        tick();
        do_reset(1);
        chk("t6_ready", resp, '0);
        chk("t6_oob", {65'd0, oob}, 66'd0);
        burst(1'b0, 3'd3, BASE, 8'd3, 2'd1, 0, 1'b0, k);
        chk("t6_pre", act[k + 1], '0);
        chk("t6_b0", act[k + 2], {1'b1, 1'b0, 64'h100});
        chk("t6_b3", act[k + 5], {1'b1, 1'b1, 64'h0000_0000_CAFE_1234});

        for (int n = 0; n < 60; n++) begin
            bit          wr, hg;
            logic [2:0]  sz;
            logic [63:0] a;
            logic [7:0]  len;
            logic [1:0]  bt;
            int          ab;
            wr = 1'($urandom_range(0, 1));
            hg = 1'($urandom_range(0, 1));
            sz = 3'($urandom_range(0, 3));
            bt = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 4))
                0:       len = 8'd0;
                1:       len = 8'd1;
                2:       len = 8'd3;
                3:       len = 8'd7;
                default: len = 8'($urandom_range(0, 20));
            endcase
            case ($urandom_range(0, 5))
                0:       a = BASE - 64'($urandom_range(1, 24));
                1:       a = BASE + 64'(MW * 8) - 64'($urandom_range(1, 24));
                2:       a = 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 15));
                default: a = BASE + 64'($urandom_range(0, MW * 8 - 1));
            endcase
            ab = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, LAT + 1 + int'(len))) : 0;
            burst(wr, sz, a, len, bt, ab, hg, k);
            if (n % 12 == 11) do_reset(1);
        end

        tick();
        tick();
        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
